bm_sequencer: RTL and testbench
===============================

Name: bm_sequencer

Overview:
- Issue controller for the Box-Muller noise datapath: log/sqrt branch on U0, cos_sine branch on U1, multiplier stage producing x0/x1.
- Accepts uniform pairs from the URNG and issues them into the fixed-latency datapath under credit control.
- Captures each returning (x0, x1) pair into a small pair FIFO and serializes it as a single-sample valid/ready noise stream.
- Sits between the URNG and the noise consumer; the datapath itself has no flow control.

Parameters:
- W, 16, sample width (U0, U1, x0, x1, out_sample).
- LAT, 4, datapath latency in cycles from dp_issue to result (1..16).
- DEPTH, 4, pair FIFO depth in pairs (power of two, >=2).

Ports:
- clk  in  1  clock, all logic on the rising edge
- rst  in  1  synchronous reset, active-high
- enable  in  1  permits new issues; in-flight pairs always complete
- urng_valid  in  1  uniform pair available
- urng_ready  out  1  pair accepted when urng_valid & urng_ready
- urng_u0  in  W  uniform for the log/sqrt branch
- urng_u1  in  W  uniform for the cos_sine branch (its U1 input)
- dp_issue  out  1  registered strobe: dp_u0/dp_u1 valid this cycle
- dp_u0  out  W  registered U0 to the datapath
- dp_u1  out  W  registered U1 to the datapath
- dp_x0  in  W  datapath result x0, sampled LAT cycles after dp_issue
- dp_x1  in  W  datapath result x1, sampled with dp_x0
- out_valid  out  1  noise sample available
- out_ready  in  1  consumer accepts
- out_sample  out  W  noise sample
- out_odd  out  1  0 = x0 of the pair, 1 = x1
- inflight  out  5  pairs issued and not yet returned
- fifo_level  out  $clog2(DEPTH)+1  pairs held in the FIFO
- pair_count  out  32  total pairs fully delivered, wraps at 2^32

Behaviour:
- Reset: on rst=1 at an edge, every output is 0 and all state is cleared (shift register, counters, FIFO pointers, serializer phase). Reset mid-operation discards in-flight and buffered pairs; their results returning after reset are ignored.
- Credit: urng_ready = enable & !rst_q & (fifo_level + inflight < DEPTH), all combinational from registers. Here rst_q is a register that is 1 during the cycle after reset, which holds urng_ready low for that first cycle.
- Issue: on an accept at cycle t, dp_issue=1 at t+1 with dp_u0/dp_u1 = the accepted values. dp_u0/dp_u1 hold their last value when dp_issue=0. A back-to-back issue every cycle is allowed.
- Return tracking: a LAT-deep shift register carries dp_issue. When its tap is 1 (cycle t+1+LAT), dp_x0/dp_x1 are written to the FIFO.
- inflight: +1 on accept, -1 on return, unchanged when both occur in the same cycle. It never exceeds DEPTH.
- FIFO: no overflow is possible by construction. An assertion must flag a write while full.
- Serializer phase: out_valid = FIFO non-empty. Phase 0 presents x0 (out_odd=0), phase 1 presents x1 (out_odd=1).
- Serializer transfer: on out_valid & out_ready, phase toggles. On a phase-1 transfer the FIFO pops and pair_count increments.
- Timing: first sample at t+2+LAT. A write and a pop in the same cycle leave fifo_level unchanged.
- out_sample/out_odd are stable while out_valid=1 and out_ready=0.
- enable=0: no new accepts. Pending returns are still captured and drained; the serializer is unaffected.
- Throughput: 1 sample/cycle sustained with out_ready=1. The pair rate is limited to 1 per 2 cycles by the output, and credit then throttles urng_ready.

Decomposition:
- Shared package (noise_pkg): W, the LAT constant of the current cos_sine/log datapath, and the pair struct {x0, x1}.
- One sub-module: pair_fifo (synchronous, DEPTH x 2W, registered count, no read latency / show-ahead).

Test Plan:
Bench datapath stub: a LAT=4 delay line returning x0=u0, x1=u1. Config DEPTH=4, LAT=4 unless noted.
- Reset: hold rst 3 cycles with urng_valid=1 -> all outputs 0 and urng_ready=0 during reset and for 1 cycle after; then urng_ready=1 with enable=1.
- Single pair: accept u0=16'h1234, u1=16'h4000 at cycle 0 -> dp_issue=1, dp_u1=16'h4000 at cycle 1. With out_ready=1: out_sample=16'h1234/odd=0 at cycle 6, then 16'h4000/odd=1 at cycle 7; pair_count=1.
- Backpressure: out_ready=0, urng_valid=1 with u1 = 16'h0000, 16'h08C0, 16'h3FFE, 16'h006E, ... -> exactly 4 accepts, then urng_ready=0, fifo_level=4, inflight=0, out_sample held. Release out_ready -> 8 samples in order, accepts resume.
- Enable drop: 2 accepts, then enable=0 -> no further accepts; both pairs (4 samples) delivered; inflight=0.
- Reset mid-run: 3 pairs in flight, rst for 1 cycle -> out_valid stays 0 for 20 cycles with urng_valid=0; fifo_level=0, inflight=0.
- Streaming: urng_valid=1 and out_ready=1 for 200 cycles -> no gaps in out_valid after the first sample; the sample sequence matches the stub; pair_count equals pairs delivered.

Source files
------------

// File: rtl/noise_pkg.sv
// Shared constants and types for the Box-Muller noise path.
package noise_pkg;
  localparam int W   = 16;
  // Latency of the current cos_sine/log/multiplier datapath
  localparam int LAT = 4;

  typedef struct packed {
    logic [W-1:0] x0;
    logic [W-1:0] x1;
  } pair_t;
endpackage

// File: rtl/bm_sequencer_if.sv
// URNG, datapath and noise-stream signals of the Box-Muller issue controller.
interface bm_sequencer_if;
  import noise_pkg::*;

  logic         urng_valid;
  logic         urng_ready;
  logic [W-1:0] urng_u0;
  logic [W-1:0] urng_u1;
  logic         dp_issue;
  logic [W-1:0] dp_u0;
  logic [W-1:0] dp_u1;
  logic [W-1:0] dp_x0;
  logic [W-1:0] dp_x1;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sample;
  logic         out_odd;

  modport slave (
    input  urng_valid, urng_u0, urng_u1, dp_x0, dp_x1, out_ready,
    output urng_ready, dp_issue, dp_u0, dp_u1, out_valid, out_sample, out_odd
  );

  modport master (
    output urng_valid, urng_u0, urng_u1, dp_x0, dp_x1, out_ready,
    input  urng_ready, dp_issue, dp_u0, dp_u1, out_valid, out_sample, out_odd
  );
endinterface

// File: rtl/bm_sequencer_pair_fifo.sv
// Show-ahead pair FIFO holding returned (x0, x1) results, plus its overflow checker.
module pair_fifo
  import noise_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  pair_t         wr_data_i,
  input  logic          rd_en_i,
  output pair_t         rd_data_o,
  output logic          empty_o,
  output logic [LW-1:0] count_o
);

  pair_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic          full_s;

  assign full_s    = (count_q == LW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_i) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_i) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_i, rd_en_i})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are only observed through a valid read pointer
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  pair_fifo_chk u_chk (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en_i (wr_en_i),
    .rd_en_i (rd_en_i),
    .full_i  (full_s),
    .empty_i (empty_o)
  );
endmodule

module pair_fifo_chk (
  input logic clk_i,
  input logic rst_i,
  input logic wr_en_i,
  input logic rd_en_i,
  input logic full_i,
  input logic empty_i
);
  a_no_overflow:  assert property (@(posedge clk_i) disable iff (rst_i) !(wr_en_i && full_i));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !(rd_en_i && empty_i));
endmodule

// File: rtl/bm_sequencer.sv
// Box-Muller issue controller: credit-gated URNG issue, fixed-latency return
// capture into a pair FIFO, and x0/x1 serialization onto the noise stream.
module bm_sequencer
  import noise_pkg::*;
#(
  parameter  int LAT   = noise_pkg::LAT,
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  bm_sequencer_if.slave bus,
  output logic [4:0]    inflight,
  output logic [LW-1:0] fifo_level,
  output logic [31:0]   pair_count
);

  logic           rst_q;
  logic           dp_issue_q, dp_issue_d;
  logic [W-1:0]   dp_u0_q, dp_u0_d;
  logic [W-1:0]   dp_u1_q, dp_u1_d;
  logic [LAT-1:0] ret_sr_q, ret_sr_d;
  logic [4:0]     inflight_q, inflight_d;
  logic           phase_q, phase_d;
  logic [31:0]    pair_count_q, pair_count_d;

  logic [5:0]     used_s;
  logic [LW-1:0]  level_s;
  logic           urng_ready_s, accept_s, ret_s, xfer_s, pop_s, empty_s;
  pair_t          ret_pair_s, head_s;

  // Credits cover both buffered and in-flight pairs, so the FIFO cannot overflow
  assign used_s       = 6'(level_s) + 6'(inflight_q);
  assign urng_ready_s = enable & ~rst_q & (used_s < 6'(DEPTH));
  assign accept_s     = bus.urng_valid & urng_ready_s;
  assign ret_s        = ret_sr_q[LAT-1];
  assign xfer_s       = ~empty_s & bus.out_ready;
  assign pop_s        = xfer_s & phase_q;
  assign ret_pair_s.x0 = bus.dp_x0;
  assign ret_pair_s.x1 = bus.dp_x1;

  // Next-state for issue, return tracking, credit and serializer
  always_comb begin
    dp_issue_d   = accept_s;
    dp_u0_d      = dp_u0_q;
    dp_u1_d      = dp_u1_q;
    ret_sr_d     = ret_sr_q;
    inflight_d   = inflight_q;
    phase_d      = phase_q;
    pair_count_d = pair_count_q;
    if (accept_s) begin
      dp_u0_d = bus.urng_u0;
      dp_u1_d = bus.urng_u1;
    end else begin
      dp_u0_d = dp_u0_q;
      dp_u1_d = dp_u1_q;
    end
    ret_sr_d[0] = dp_issue_q;
    for (int i = 1; i < LAT; i++) begin
      ret_sr_d[i] = ret_sr_q[i-1];
    end
    case ({accept_s, ret_s})
      2'b10:   inflight_d = inflight_q + 5'd1;
      2'b01:   inflight_d = inflight_q - 5'd1;
      default: inflight_d = inflight_q;
    endcase
    if (xfer_s) begin
      phase_d = ~phase_q;
    end else begin
      phase_d = phase_q;
    end
    if (pop_s) begin
      pair_count_d = pair_count_q + 32'd1;
    end else begin
      pair_count_d = pair_count_q;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q        <= 1'b1;
      dp_issue_q   <= 1'b0;
      dp_u0_q      <= '0;
      dp_u1_q      <= '0;
      ret_sr_q     <= '0;
      inflight_q   <= 5'd0;
      phase_q      <= 1'b0;
      pair_count_q <= 32'd0;
    end else begin
      rst_q        <= 1'b0;
      dp_issue_q   <= dp_issue_d;
      dp_u0_q      <= dp_u0_d;
      dp_u1_q      <= dp_u1_d;
      ret_sr_q     <= ret_sr_d;
      inflight_q   <= inflight_d;
      phase_q      <= phase_d;
      pair_count_q <= pair_count_d;
    end
  end

  pair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (ret_s),
    .wr_data_i (ret_pair_s),
    .rd_en_i   (pop_s),
    .rd_data_o (head_s),
    .empty_o   (empty_s),
    .count_o   (level_s)
  );

  assign bus.urng_ready = urng_ready_s;
  assign bus.dp_issue   = dp_issue_q;
  assign bus.dp_u0      = dp_u0_q;
  assign bus.dp_u1      = dp_u1_q;
  assign bus.out_valid  = ~empty_s;
  assign bus.out_sample = empty_s ? '0 : (phase_q ? head_s.x1 : head_s.x0);
  assign bus.out_odd    = phase_q;
  assign inflight       = inflight_q;
  assign fifo_level     = level_s;
  assign pair_count     = pair_count_q;
endmodule

// File: tb/tb_bm_sequencer.sv
// Directed bench for bm_sequencer with a LAT-cycle echo stub (x0=u0, x1=u1).
module tb_bm_sequencer;
  localparam int DEPTH = 4;
  localparam int TLAT  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [4:0]  inflight;
  logic [2:0]  fifo_level;
  logic [31:0] pair_count;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q [$];
  logic [15:0] st0 [TLAT];
  logic [15:0] st1 [TLAT];
  logic [15:0] bp_u1 [8] = '{16'h0000, 16'h08C0, 16'h3FFE, 16'h006E,
                             16'h1111, 16'h2222, 16'h3333, 16'h4444};

  bm_sequencer_if bus ();

  bm_sequencer #(.LAT(TLAT), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .bus        (bus),
    .inflight   (inflight),
    .fifo_level (fifo_level),
    .pair_count (pair_count)
  );

  always #5 clk = ~clk;

  // Datapath stub: fixed delay line echoing the issued uniforms
  always @(posedge clk) begin
    st0[0] <= bus.dp_u0;
    st1[0] <= bus.dp_u1;
    for (int i = 1; i < TLAT; i++) begin
      st0[i] <= st0[i-1];
      st1[i] <= st1[i-1];
    end
  end
  assign bus.dp_x0 = st0[TLAT-1];
  assign bus.dp_x1 = st1[TLAT-1];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; bus.out_ready = 1'b1;
    bus.urng_valid = 1'b1; bus.urng_u0 = 16'hAAAA; bus.urng_u1 = 16'h5555;
    repeat (3) begin
      cyc();
      checks++;
      if ({bus.urng_ready, bus.dp_issue, bus.out_valid, bus.out_odd} !== 4'b0000 ||
          bus.dp_u0 !== 16'h0 || bus.dp_u1 !== 16'h0 || bus.out_sample !== 16'h0 ||
          inflight !== 5'd0 || fifo_level !== 3'd0 || pair_count !== 32'd0) begin
        errors++;
        $display("FAIL reset_outputs rdy=%b iss=%b ov=%b odd=%b u0=%h u1=%h smp=%h infl=%0d lvl=%0d pc=%0d required all 0",
                 bus.urng_ready, bus.dp_issue, bus.out_valid, bus.out_odd, bus.dp_u0, bus.dp_u1,
                 bus.out_sample, inflight, fifo_level, pair_count);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.urng_ready !== 1'b0 || inflight !== 5'd0) begin
      errors++;
      $display("FAIL post_reset_ready got rdy=%b infl=%0d required rdy=0 infl=0", bus.urng_ready, inflight);
    end
    cyc();
    checks++;
    if (bus.urng_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got %b required 1", bus.urng_ready);
    end
    bus.urng_valid = 1'b0;
  endtask

  task automatic test_single();
    bus.urng_u0 = 16'h1234; bus.urng_u1 = 16'h4000; bus.urng_valid = 1'b1; bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.urng_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready got %b required 1", bus.urng_ready);
    end
    cyc();
    bus.urng_valid = 1'b0;
    checks++;
    if (bus.dp_issue !== 1'b1 || bus.dp_u0 !== 16'h1234 || bus.dp_u1 !== 16'h4000 || inflight !== 5'd1) begin
      errors++;
      $display("FAIL single_issue got iss=%b u0=%h u1=%h infl=%0d required 1 1234 4000 1",
               bus.dp_issue, bus.dp_u0, bus.dp_u1, inflight);
    end
    cyc();
    checks++;
    if (bus.dp_issue !== 1'b0 || bus.dp_u1 !== 16'h4000) begin
      errors++;
      $display("FAIL single_hold got iss=%b u1=%h required 0 4000", bus.dp_issue, bus.dp_u1);
    end
    repeat (3) cyc();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early got out_valid=%b required 0 at cycle 5", bus.out_valid);
    end
    cyc();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sample !== 16'h1234 || bus.out_odd !== 1'b0 ||
        fifo_level !== 3'd1 || inflight !== 5'd0) begin
      errors++;
      $display("FAIL single_x0 got ov=%b smp=%h odd=%b lvl=%0d infl=%0d required 1 1234 0 1 0",
               bus.out_valid, bus.out_sample, bus.out_odd, fifo_level, inflight);
    end
    cyc();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sample !== 16'h4000 || bus.out_odd !== 1'b1 || pair_count !== 32'd0) begin
      errors++;
      $display("FAIL single_x1 got ov=%b smp=%h odd=%b pc=%0d required 1 4000 1 0",
               bus.out_valid, bus.out_sample, bus.out_odd, pair_count);
    end
    cyc();
    checks++;
    if (bus.out_valid !== 1'b0 || pair_count !== 32'd1 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL single_done got ov=%b pc=%0d lvl=%0d required 0 1 0", bus.out_valid, pair_count, fifo_level);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int xf = 0;
    exp_q.delete();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      bus.urng_valid = 1'b1;
      bus.urng_u0 = 16'hA000 + 16'(acc);
      bus.urng_u1 = bp_u1[acc[2:0]];
      #1;
      if (bus.urng_valid && bus.urng_ready) begin
        exp_q.push_back(bus.urng_u0); exp_q.push_back(bus.urng_u1); acc++;
      end
      if (bus.out_valid) begin
        checks++;
        if (bus.out_sample !== 16'hA000 || bus.out_odd !== 1'b0) begin
          errors++;
          $display("FAIL bp_hold got smp=%h odd=%b required A000 0", bus.out_sample, bus.out_odd);
        end
      end
      cyc();
    end
    bus.urng_valid = 1'b1;
    #1;
    checks++;
    if (acc !== 4 || bus.urng_ready !== 1'b0 || fifo_level !== 3'd4 || inflight !== 5'd0) begin
      errors++;
      $display("FAIL bp_full got acc=%0d rdy=%b lvl=%0d infl=%0d required 4 0 4 0",
               acc, bus.urng_ready, fifo_level, inflight);
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      bus.urng_valid = (acc < 8);
      bus.urng_u0 = 16'hA000 + 16'(acc);
      bus.urng_u1 = bp_u1[acc[2:0]];
      #1;
      if (bus.urng_valid && bus.urng_ready) begin
        exp_q.push_back(bus.urng_u0); exp_q.push_back(bus.urng_u1); acc++;
      end
      if (bus.out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bp_extra got smp=%h required no sample", bus.out_sample);
        end else if (bus.out_sample !== exp_q[0] || bus.out_odd !== xf[0]) begin
          errors++;
          $display("FAIL bp_order got smp=%h odd=%b required %h %b", bus.out_sample, bus.out_odd, exp_q[0], xf[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        xf++;
      end
      cyc();
    end
    bus.urng_valid = 1'b0;
    checks++;
    if (xf !== 16 || acc !== 8 || exp_q.size() !== 0 || pair_count !== 32'd9) begin
      errors++;
      $display("FAIL bp_drain got xf=%0d acc=%0d left=%0d pc=%0d required 16 8 0 9", xf, acc, exp_q.size(), pair_count);
    end
  endtask

  task automatic test_enable_drop();
    int acc = 0;
    int xf = 0;
    exp_q.delete();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      enable = (acc < 2);
      bus.urng_valid = 1'b1;
      bus.urng_u0 = 16'hC000 + 16'(acc);
      bus.urng_u1 = 16'hC100 + 16'(acc);
      #1;
      if (!enable) begin
        checks++;
        if (bus.urng_ready !== 1'b0) begin
          errors++;
          $display("FAIL en_ready got %b required 0", bus.urng_ready);
        end
      end
      if (bus.urng_valid && bus.urng_ready) begin
        exp_q.push_back(bus.urng_u0); exp_q.push_back(bus.urng_u1); acc++;
      end
      if (bus.out_valid) begin
        checks++;
        if (exp_q.size() == 0 || bus.out_sample !== exp_q[0] || bus.out_odd !== xf[0]) begin
          errors++;
          $display("FAIL en_order got smp=%h odd=%b required %h %b", bus.out_sample, bus.out_odd,
                   (exp_q.size() != 0) ? exp_q[0] : 16'hxxxx, xf[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        xf++;
      end
      cyc();
    end
    bus.urng_valid = 1'b0;
    checks++;
    if (acc !== 2 || xf !== 4 || inflight !== 5'd0 || fifo_level !== 3'd0 || pair_count !== 32'd11) begin
      errors++;
      $display("FAIL en_drain got acc=%0d xf=%0d infl=%0d lvl=%0d pc=%0d required 2 4 0 0 11",
               acc, xf, inflight, fifo_level, pair_count);
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_midrun();
    int acc = 0;
    int bad = 0;
    exp_q.delete();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10 && acc < 3; c++) begin
      bus.urng_valid = 1'b1;
      bus.urng_u0 = 16'hE000 + 16'(acc);
      bus.urng_u1 = 16'hE100 + 16'(acc);
      #1;
      if (bus.urng_valid && bus.urng_ready) acc++;
      cyc();
    end
    bus.urng_valid = 1'b0;
    checks++;
    if (acc !== 3 || inflight !== 5'd3) begin
      errors++;
      $display("FAIL mid_setup got acc=%0d infl=%0d required 3 3", acc, inflight);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if (inflight !== 5'd0 || fifo_level !== 3'd0 || pair_count !== 32'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got infl=%0d lvl=%0d pc=%0d ov=%b required 0 0 0 0",
               inflight, fifo_level, pair_count, bus.out_valid);
    end
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (bus.out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0 || fifo_level !== 3'd0 || inflight !== 5'd0) begin
      errors++;
      $display("FAIL mid_quiet got valid_cycles=%0d lvl=%0d infl=%0d required 0 0 0", bad, fifo_level, inflight);
    end
  endtask

  task automatic test_streaming();
    int acc = 0;
    int xf = 0;
    int gaps = 0;
    int bad = 0;
    bit started = 1'b0;
    exp_q.delete();
    enable = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 230; c++) begin
      bus.urng_valid = (c < 200);
      bus.urng_u0 = 16'h1000 ^ 16'(acc * 37);
      bus.urng_u1 = ~(16'h1000 ^ 16'(acc * 37));
      #1;
      if (bus.urng_valid && bus.urng_ready) begin
        exp_q.push_back(bus.urng_u0); exp_q.push_back(bus.urng_u1); acc++;
      end
      if (bus.out_valid) begin
        started = 1'b1;
        if (exp_q.size() == 0 || bus.out_sample !== exp_q[0] || bus.out_odd !== xf[0]) begin
          bad++;
          if (bad <= 4)
            $display("FAIL stream_sample got smp=%h odd=%b required %h %b", bus.out_sample, bus.out_odd,
                     (exp_q.size() != 0) ? exp_q[0] : 16'hxxxx, xf[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        xf++;
      end else if (started && c < 200) begin
        gaps++;
      end
      cyc();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL stream_order got %0d bad samples required 0", bad);
    end
    checks++;
    if (gaps !== 0) begin
      errors++;
      $display("FAIL stream_gaps got %0d required 0", gaps);
    end
    checks++;
    if (acc < 96 || xf !== 2 * acc || exp_q.size() !== 0 || pair_count !== 32'(acc)) begin
      errors++;
      $display("FAIL stream_count got acc=%0d xf=%0d left=%0d pc=%0d required acc>=96 xf=%0d left=0 pc=%0d",
               acc, xf, exp_q.size(), pair_count, 2 * acc, acc);
    end
  endtask

  initial begin
    bus.urng_valid = 1'b0; bus.urng_u0 = 16'h0; bus.urng_u1 = 16'h0; bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_enable_drop();
    test_reset_midrun();
    test_streaming();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got still running required finished");
    $fatal(1, "timeout");
  end
endmodule
